// File: rtl/ascensor_pkg.sv
// Shared encodings for the elevator dispatcher and the per-car sequencers.
package ascensor_pkg;

  localparam logic [1:0] DIR_NADA   = 2'b00;
  localparam logic [1:0] DIR_ARRIBA = 2'b01;
  localparam logic [1:0] DIR_ABAJO  = 2'b10;

  localparam logic [2:0] DESTINO_NADA = 3'b100;

  localparam logic [1:0] PISO_M1 = 2'd0;
  localparam logic [1:0] PISO_1  = 2'd1;
  localparam logic [1:0] PISO_2  = 2'd2;
  localparam logic [1:0] PISO_3  = 2'd3;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    MOVIENDO = 2'd1,
    PUERTA   = 2'd2
  } estado_cabina_t;

endpackage

// File: rtl/temporizador_ascensor.sv
// Up-counter shared by travel and door dwell. fin is registered and is high
// exactly while the count equals limite, so the sequencer can clear the
// counter on the same edge it acts on the terminal count.
module temporizador_ascensor #(
  parameter int ANCHO_CONT = 27
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  borrar,
  input  logic                  habilitar,
  input  logic [ANCHO_CONT-1:0] limite,
  output logic                  fin
);

  localparam logic [ANCHO_CONT-1:0] UNO = ANCHO_CONT'(1);

  logic [ANCHO_CONT-1:0] cuenta;
  logic [ANCHO_CONT-1:0] cuenta_sig;

  assign cuenta_sig = cuenta + UNO;

  // Count while enabled; clear has priority over counting.
  always_ff @(posedge clk) begin
    if (reset || borrar) begin
      cuenta <= '0;
      fin    <= 1'b0;
    end else if (habilitar) begin
      cuenta <= cuenta_sig;
      fin    <= (cuenta_sig == limite);
    end
  end

endmodule

// File: rtl/control_cabina_ascensor.sv
// Per-car sequencer: accepts a destination from the dispatcher, steps the car
// one floor per travel period, then holds the door open for the dwell time.
//
// state    | meaning
// REPOSO   | idle, door closed, sampling destino_asc for a new request
// MOVIENDO | travelling, floor steps by one every TIEMPO_VIAJE cycles
// PUERTA   | door open, dwell restarts while boton_abrir is held
module control_cabina_ascensor
  import ascensor_pkg::*;
#(
  parameter int         TIEMPO_VIAJE  = 100000000,
  parameter int         TIEMPO_PUERTA = 100000000,
  parameter int         ANCHO_CONT    = 27,
  parameter logic [1:0] PISO_INICIAL  = 2'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] destino_asc,
  input  logic       boton_abrir,
  output logic [1:0] piso_asc,
  output logic [1:0] direccion_asc,
  output logic       ocupado_asc,
  output logic       puerta_abierta,
  output logic       llegada
);

  localparam logic [ANCHO_CONT-1:0] FIN_VIAJE  = ANCHO_CONT'(TIEMPO_VIAJE - 1);
  localparam logic [ANCHO_CONT-1:0] FIN_PUERTA = ANCHO_CONT'(TIEMPO_PUERTA - 1);

  estado_cabina_t estado, estado_d;
  logic [1:0] objetivo, objetivo_d;
  logic [2:0] ultimo_destino, ultimo_destino_d;
  logic [1:0] piso_d, direccion_d, piso_sig;
  logic       ocupado_d, puerta_d, llegada_d;

  logic                  tmr_borrar, tmr_habilitar, tmr_fin;
  logic [ANCHO_CONT-1:0] tmr_limite;

  // Travel and dwell never overlap, so one counter serves both.
  assign tmr_limite = (estado == PUERTA) ? FIN_PUERTA : FIN_VIAJE;

  temporizador_ascensor #(
    .ANCHO_CONT(ANCHO_CONT)
  ) u_temporizador (
    .clk      (clk),
    .reset    (reset),
    .borrar   (tmr_borrar),
    .habilitar(tmr_habilitar),
    .limite   (tmr_limite),
    .fin      (tmr_fin)
  );

  assign piso_sig = (direccion_asc == DIR_ARRIBA) ? piso_asc + 2'd1 : piso_asc - 2'd1;

  // State and all outputs are registered; reset snaps the car to the home floor.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado         <= REPOSO;
      objetivo       <= PISO_INICIAL;
      ultimo_destino <= DESTINO_NADA;
      piso_asc       <= PISO_INICIAL;
      direccion_asc  <= DIR_NADA;
      ocupado_asc    <= 1'b0;
      puerta_abierta <= 1'b0;
      llegada        <= 1'b0;
    end else begin
      estado         <= estado_d;
      objetivo       <= objetivo_d;
      ultimo_destino <= ultimo_destino_d;
      piso_asc       <= piso_d;
      direccion_asc  <= direccion_d;
      ocupado_asc    <= ocupado_d;
      puerta_abierta <= puerta_d;
      llegada        <= llegada_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    estado_d         = estado;
    objetivo_d       = objetivo;
    ultimo_destino_d = ultimo_destino;
    piso_d           = piso_asc;
    direccion_d      = direccion_asc;
    ocupado_d        = ocupado_asc;
    puerta_d         = puerta_abierta;
    llegada_d        = 1'b0;
    tmr_borrar       = 1'b0;
    tmr_habilitar    = 1'b0;

    case (estado)
      REPOSO: begin
        tmr_borrar = 1'b1;
        ocupado_d  = 1'b0;
        // The dispatcher holds its output, so only a changed value is a request.
        if (!destino_asc[2] && (destino_asc != ultimo_destino)) begin
          ultimo_destino_d = destino_asc;
          objetivo_d       = destino_asc[1:0];
          ocupado_d        = 1'b1;
          if (destino_asc[1:0] == piso_asc) begin
            estado_d    = PUERTA;
            direccion_d = DIR_NADA;
            puerta_d    = 1'b1;
            llegada_d   = 1'b1;
          end else begin
            estado_d    = MOVIENDO;
            direccion_d = (destino_asc[1:0] > piso_asc) ? DIR_ARRIBA : DIR_ABAJO;
          end
        end
      end

      MOVIENDO: begin
        tmr_habilitar = 1'b1;
        if (tmr_fin) begin
          tmr_borrar = 1'b1;
          piso_d     = piso_sig;
          if (piso_sig == objetivo) begin
            estado_d    = PUERTA;
            direccion_d = DIR_NADA;
            puerta_d    = 1'b1;
            llegada_d   = 1'b1;
          end
        end
      end

      PUERTA: begin
        tmr_habilitar = 1'b1;
        if (boton_abrir) begin
          tmr_borrar = 1'b1;
        end else if (tmr_fin) begin
          tmr_borrar = 1'b1;
          estado_d   = REPOSO;
          puerta_d   = 1'b0;
          ocupado_d  = 1'b0;
        end
      end

      default: begin
        estado_d = REPOSO;
      end
    endcase
  end

  // The target is always inside 0..3 and travel is towards it, so a floor
  // step past either end means the sequencing logic is broken.
  a_piso_en_rango: assert property (@(posedge clk) disable iff (reset)
    (estado == MOVIENDO && tmr_fin) |->
      !((direccion_asc == DIR_ARRIBA && piso_asc == PISO_3) ||
        (direccion_asc == DIR_ABAJO  && piso_asc == PISO_M1)));

endmodule

// File: tb/tb_control_cabina_ascensor.sv
// Directed bench for the per-car sequencer with short travel/dwell times.
// Observed vector is {piso[1:0], direccion[1:0], ocupado, puerta, llegada}.
module tb_control_cabina_ascensor;

  localparam int TV = 4;
  localparam int TP = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] destino_asc;
  logic       boton_abrir;
  logic [1:0] piso_asc;
  logic [1:0] direccion_asc;
  logic       ocupado_asc;
  logic       puerta_abierta;
  logic       llegada;
  logic [6:0] obs;

  int checks = 0;
  int errors = 0;

  control_cabina_ascensor #(
    .TIEMPO_VIAJE (TV),
    .TIEMPO_PUERTA(TP),
    .ANCHO_CONT   (4),
    .PISO_INICIAL (2'd0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .destino_asc   (destino_asc),
    .boton_abrir   (boton_abrir),
    .piso_asc      (piso_asc),
    .direccion_asc (direccion_asc),
    .ocupado_asc   (ocupado_asc),
    .puerta_abierta(puerta_abierta),
    .llegada       (llegada)
  );

  always #5 clk = ~clk;

  assign obs = {piso_asc, direccion_asc, ocupado_asc, puerta_abierta, llegada};

  task automatic ciclo();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    destino_asc = 3'b100;
    boton_abrir = 1'b0;
    ciclo();
    ciclo();
    checks++;
    if (obs !== 7'b00_00_000) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b", obs, 7'b00_00_000);
    end
    reset = 1'b0;
  endtask

  // 0 -> 3: floors change at +5/+9/+13, door open +13..+15, idle at +16.
  task automatic test_subida();
    logic [6:0] exp_v;
    logic [1:0] pe;
    destino_asc = 3'b011;
    for (int k = 1; k <= 16; k++) begin
      ciclo();
      pe = (k < 5) ? 2'd0 : (k < 9) ? 2'd1 : (k < 13) ? 2'd2 : 2'd3;
      exp_v = {pe, (k <= 12) ? 2'b01 : 2'b00, 1'(k <= 15),
               1'(k >= 13 && k <= 15), 1'(k == 13)};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL subida k=%0d: got %b expected %b", k, obs, exp_v);
      end
    end
  endtask

  // Held level is not re-accepted; then 3 -> 0.
  task automatic test_mantenido();
    logic [6:0] exp_v;
    logic [1:0] pe;
    for (int k = 1; k <= 20; k++) begin
      ciclo();
      checks++;
      if ({ocupado_asc, piso_asc} !== 3'b0_11) begin
        errors++;
        $display("FAIL mantenido k=%0d: got ocupado,piso=%b expected 011", k, {ocupado_asc, piso_asc});
      end
    end
    destino_asc = 3'b000;
    for (int k = 1; k <= 16; k++) begin
      ciclo();
      pe = (k < 5) ? 2'd3 : (k < 9) ? 2'd2 : (k < 13) ? 2'd1 : 2'd0;
      exp_v = {pe, (k <= 12) ? 2'b10 : 2'b00, 1'(k <= 15),
               1'(k >= 13 && k <= 15), 1'(k == 13)};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL bajada k=%0d: got %b expected %b", k, obs, exp_v);
      end
    end
  endtask

  // After reset ultimo_destino is null, so 000 at floor 0 opens the door at once.
  task automatic test_mismo_piso();
    reset = 1'b1;
    ciclo();
    reset       = 1'b0;
    destino_asc = 3'b000;
    ciclo();
    checks++;
    if (obs !== 7'b00_00_111) begin
      errors++;
      $display("FAIL mismo_piso_llegada: got %b expected %b", obs, 7'b00_00_111);
    end
    ciclo();
    ciclo();
    checks++;
    if (obs !== 7'b00_00_110) begin
      errors++;
      $display("FAIL mismo_piso_puerta: got %b expected %b", obs, 7'b00_00_110);
    end
    ciclo();
    checks++;
    if (obs !== 7'b00_00_000) begin
      errors++;
      $display("FAIL mismo_piso_cierre: got %b expected %b", obs, 7'b00_00_000);
    end
    destino_asc = 3'b001;
    ciclo();
    checks++;
    if (obs !== 7'b00_01_100) begin
      errors++;
      $display("FAIL un_piso_salida: got %b expected %b", obs, 7'b00_01_100);
    end
    repeat (4) ciclo();
    checks++;
    if (obs !== 7'b01_00_111) begin
      errors++;
      $display("FAIL un_piso_llegada: got %b expected %b", obs, 7'b01_00_111);
    end
    repeat (3) ciclo();
    checks++;
    if (obs !== 7'b01_00_000) begin
      errors++;
      $display("FAIL un_piso_reposo: got %b expected %b", obs, 7'b01_00_000);
    end
  endtask

  task automatic test_puerta();
    destino_asc = 3'b010;
    repeat (5) ciclo();
    checks++;
    if (obs !== 7'b10_00_111) begin
      errors++;
      $display("FAIL puerta_llegada: got %b expected %b", obs, 7'b10_00_111);
    end
    ciclo();
    boton_abrir = 1'b1;
    ciclo();
    boton_abrir = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) ciclo();
      checks++;
      if (puerta_abierta !== 1'b1) begin
        errors++;
        $display("FAIL puerta_pulso k=%0d: got %b expected 1", k, puerta_abierta);
      end
    end
    ciclo();
    checks++;
    if (obs !== 7'b10_00_000) begin
      errors++;
      $display("FAIL puerta_pulso_cierre: got %b expected %b", obs, 7'b10_00_000);
    end
    destino_asc = 3'b011;
    repeat (5) ciclo();
    checks++;
    if (obs !== 7'b11_00_111) begin
      errors++;
      $display("FAIL puerta2_llegada: got %b expected %b", obs, 7'b11_00_111);
    end
    boton_abrir = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      ciclo();
      checks++;
      if (puerta_abierta !== 1'b1) begin
        errors++;
        $display("FAIL puerta_mantenida k=%0d: got %b expected 1", k, puerta_abierta);
      end
    end
    boton_abrir = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      ciclo();
      checks++;
      if (puerta_abierta !== 1'b1) begin
        errors++;
        $display("FAIL puerta_suelta k=%0d: got %b expected 1", k, puerta_abierta);
      end
    end
    ciclo();
    checks++;
    if (obs !== 7'b11_00_000) begin
      errors++;
      $display("FAIL puerta_suelta_cierre: got %b expected %b", obs, 7'b11_00_000);
    end
  endtask

  // Command change during travel is ignored until REPOSO; reset mid-travel snaps home.
  task automatic test_cambio_y_reset();
    destino_asc = 3'b000;
    ciclo();
    ciclo();
    destino_asc = 3'b010;
    repeat (3) ciclo();
    checks++;
    if (obs !== 7'b10_10_100) begin
      errors++;
      $display("FAIL cambio_paso_piso2: got %b expected %b", obs, 7'b10_10_100);
    end
    repeat (4) ciclo();
    checks++;
    if (obs !== 7'b01_10_100) begin
      errors++;
      $display("FAIL cambio_piso1: got %b expected %b", obs, 7'b01_10_100);
    end
    repeat (4) ciclo();
    checks++;
    if (obs !== 7'b00_00_111) begin
      errors++;
      $display("FAIL cambio_llegada0: got %b expected %b", obs, 7'b00_00_111);
    end
    repeat (3) ciclo();
    checks++;
    if (obs !== 7'b00_00_000) begin
      errors++;
      $display("FAIL cambio_reposo: got %b expected %b", obs, 7'b00_00_000);
    end
    ciclo();
    checks++;
    if (obs !== 7'b00_01_100) begin
      errors++;
      $display("FAIL cambio_aceptado: got %b expected %b", obs, 7'b00_01_100);
    end
    repeat (4) ciclo();
    checks++;
    if (obs !== 7'b01_01_100) begin
      errors++;
      $display("FAIL cambio_piso1_subiendo: got %b expected %b", obs, 7'b01_01_100);
    end
    reset = 1'b1;
    ciclo();
    checks++;
    if (obs !== 7'b00_00_000) begin
      errors++;
      $display("FAIL reset_en_viaje: got %b expected %b", obs, 7'b00_00_000);
    end
    destino_asc = 3'b100;
    reset       = 1'b0;
  endtask

  task automatic test_nulo();
    for (int k = 1; k <= 10; k++) begin
      ciclo();
      checks++;
      if (obs !== 7'b00_00_000) begin
        errors++;
        $display("FAIL nulo k=%0d: got %b expected %b", k, obs, 7'b00_00_000);
      end
    end
  endtask

  initial begin
    test_reset();
    test_subida();
    test_mantenido();
    test_mismo_piso();
    test_puerta();
    test_cambio_y_reset();
    test_nulo();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
